// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module : sqrt_pkg
// Brief  : Shared types and sizing helpers for the iterative square-root unit.
//          Provides the FSM state encoding and width/latency functions that
//          derive from the radical width W.
// Rev    : 1.0  initial release
// ============================================================================
package sqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Clock edges from the accept edge to out_valid rising: one root bit per edge.
    function automatic int sqrt_latency(input int w);
        return w / 2;
    endfunction

    // Width of the integer root for a W-bit radical.
    function automatic int root_w(input int w);
        return w / 2;
    endfunction

endpackage : sqrt_pkg
`default_nettype wire

// File: rtl/sqrt_step.sv
`default_nettype none
// ============================================================================
// Module : sqrt_step
// Brief  : One combinational iteration of the restoring digit-by-digit
//          square root. Brings down the next two radicand bits, trials the
//          (root<<2)|1 subtrahend and emits the next remainder and root.
// Ports  : rem      - current partial remainder (RW+2 bits)
//          root     - current partial root (RW bits)
//          bits     - next two unconsumed radicand bits, MSB first
//          rem_nxt  - partial remainder after this iteration
//          root_nxt - partial root after this iteration
// Rev    : 1.0  initial release
// ============================================================================
module sqrt_step #(
    parameter int RW = 8
) (
    input  logic [RW+1:0] rem,
    input  logic [RW-1:0] root,
    input  logic [1:0]    bits,
    output logic [RW+1:0] rem_nxt,
    output logic [RW-1:0] root_nxt
);

    logic [RW+1:0] w_shift;
    logic [RW+1:0] w_trial;
    logic          w_unused_hi;

    // The partial remainder never exceeds 2*root before the shift, so its top
    // two bits are always zero here and the shifted value fits in RW+2 bits.
    assign w_shift     = {rem[RW-1:0], bits};
    assign w_trial     = {root, 2'b01};
    assign w_unused_hi = &{1'b0, rem[RW+1:RW]};

    always_comb begin
        rem_nxt  = w_shift;
        root_nxt = {root[RW-2:0], 1'b0};
        if (w_shift >= w_trial) begin
            rem_nxt  = w_shift - w_trial;
            root_nxt = {root[RW-2:0], 1'b1};
        end
    end

endmodule : sqrt_step
`default_nettype wire

// File: rtl/sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module : sqrt_iter
// Brief  : Handshaked iterative integer square root. Computes
//          q = floor(sqrt(radical)) and remainder = radical - q*q, one root
//          bit per clock, with an opaque tag carried through.
// Ports  : clk, rst                 - clock, synchronous active-high reset
//          in_valid/in_ready        - operand handshake
//          radical, in_tag          - operand and its tag
//          out_valid/out_ready      - result handshake
//          q, remainder, out_tag    - result and echoed tag
// Rev    : 1.0  initial release
// ============================================================================
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter int W     = 16,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          radical,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W/2-1:0]        q,
    output logic [W/2:0]          remainder,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int c_rw = root_w(W);
    localparam int c_cw = (c_rw > 1) ? $clog2(c_rw) : 1;
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(sqrt_latency(W) - 1);

    generate
        if ((W % 2) != 0 || W < 4) begin : g_bad_w
            $error("sqrt_iter: W must be even and >= 4");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("sqrt_iter: TAG_W must be >= 1");
        end
    endgenerate

    state_t            r_state;
    logic [W-1:0]      r_rad;
    logic [c_rw+1:0]   r_rem;
    logic [c_rw-1:0]   r_root;
    logic [c_cw-1:0]   r_cnt;
    logic [TAG_W-1:0]  r_tag;

    logic [c_rw+1:0]   w_rem_nxt;
    logic [c_rw-1:0]   w_root_nxt;

    sqrt_step #(
        .RW       (c_rw)
    ) u_step (
        .rem      (r_rem),
        .root     (r_root),
        .bits     (r_rad[W-1:W-2]),
        .rem_nxt  (w_rem_nxt),
        .root_nxt (w_root_nxt)
    );

    // A finishing result can hand off and a new operand be taken on the
    // same edge, which keeps back-to-back operations gap-free.
    assign in_ready = !rst && ((r_state == S_IDLE) ||
                               ((r_state == S_DONE) && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            q         <= '0;
            remainder <= '0;
            out_tag   <= '0;
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            r_tag     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rad   <= radical;
                        r_tag   <= in_tag;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= c_cnt_init;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rad  <= {r_rad[W-3:0], 2'b00};
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        q         <= w_root_nxt;
                        // Final remainder is at most 2q, so W/2+1 bits hold it.
                        remainder <= w_rem_nxt[c_rw:0];
                        out_tag   <= r_tag;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            r_rad   <= radical;
                            r_tag   <= in_tag;
                            r_rem   <= '0;
                            r_root  <= '0;
                            r_cnt   <= c_cnt_init;
                            r_state <= S_CALC;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : sqrt_iter
`default_nettype wire

// File: tb/tb_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module : tb_sqrt_iter
// Brief  : Self-checking bench for sqrt_iter (W=16, TAG_W=4). Accepted
//          operands are scored against an arithmetic reference model and
//          checked in order by a monitor, including latency and hold rules.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sqrt_iter;

    localparam int W     = 16;
    localparam int TAG_W = 4;
    localparam int LAT   = W / 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       radical;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [W/2-1:0]     q;
    logic [W/2:0]       remainder;
    logic [TAG_W-1:0]   out_tag;

    sqrt_iter #(
        .W         (W),
        .TAG_W     (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .radical   (radical),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .remainder (remainder),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned rad;
        int unsigned tag;
        int unsigned q;
        int unsigned rem;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t e_front;
    exp_t e_new;
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   mode   = 0;   // 0: always ready, 1: random stalls, 2: hold not-ready
    bit   hold   = 1'b0;
    int unsigned hq, hr, ht;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: largest q with q*q <= r, found by plain search.
    function automatic int unsigned isqrt(input int unsigned r);
        int unsigned s = 0;
        while ((s + 1) * (s + 1) <= r) s++;
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard: inputs are stable at the falling edge, so the
    // handshakes seen here are the ones that fire on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_during_reset", in_ready, 0);
            sb.delete();
            hold = 1'b0;
        end else begin
            if (hold) check("valid_held_under_stall", out_valid, 1);
            if (out_valid && !hold) begin
                if (sb.size() == 0) begin
                    check("result_without_request", sb.size(), 1);
                end else begin
                    e_front = sb[0];
                    check("latency", cyc, e_front.acc + 1 + LAT);
                    check("q", q, e_front.q);
                    check("remainder", remainder, e_front.rem);
                    check("tag", out_tag, e_front.tag);
                    check("identity", int'(q) * int'(q) + int'(remainder), e_front.rad);
                    check("rem_le_2q", (int'(remainder) <= 2 * int'(q)) ? 1 : 0, 1);
                end
            end
            if (out_valid && hold) begin
                check("q_stable", q, hq);
                check("rem_stable", remainder, hr);
                check("tag_stable", out_tag, ht);
            end
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            if (out_valid && !out_ready) begin
                check("in_ready_while_stalled", in_ready, 0);
                hq = q;
                hr = remainder;
                ht = out_tag;
            end
            hold = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                e_new.rad = radical;
                e_new.tag = in_tag;
                e_new.q   = isqrt(radical);
                e_new.rem = radical - e_new.q * e_new.q;
                e_new.acc = cyc;
                sb.push_back(e_new);
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        if (!in_ready) check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input int unsigned r, input int unsigned t);
        @(posedge clk);
        #1;
        radical  = W'(r);
        in_tag   = TAG_W'(t);
        in_valid = 1'b1;
        wait_accept();
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || out_valid) && n < 2000);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    int unsigned dir_rad [8] = '{4, 6, 9, 144, 21549, 0, 65535, 65025};

    initial begin
        int n;
        int unsigned r;
        rst      = 1'b1;
        in_valid = 1'b0;
        radical  = '0;
        in_tag   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_q", q, 0);
        check("reset_rem", remainder, 0);
        check("reset_tag", out_tag, 0);
        check("in_ready_after_reset", in_ready, 1);

        // Directed operands, including both extremes.
        mode = 0;
        for (int i = 0; i < 8; i++) send(dir_rad[i], i + 1);
        wait_drain();

        // Backpressure with a pending operand, then same-cycle hand-off.
        mode = 2;
        send(21549, 3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) check("result_timeout", out_valid, 1);
        @(posedge clk);
        #1;
        radical  = 16'd100;
        in_tag   = 4'd7;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("pending_not_consumed", in_ready, 0);
        end
        mode = 0;
        wait_accept();
        wait_drain();

        // Reset during the third iteration discards the operation.
        send(1234, 5);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_q", q, 0);
        check("midreset_rem", remainder, 0);
        check("midreset_tag", out_tag, 0);
        check("midreset_in_ready", in_ready, 1);
        send(49, 9);
        wait_drain();

        // Random operands with random consumer stalls.
        mode = 1;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 15))
                0:       r = 0;
                1:       r = 65535;
                2:       r = $urandom_range(0, 255) ** 2;
                default: r = $urandom_range(0, 65535);
            endcase
            send(r, $urandom_range(0, 15));
        end
        wait_drain();
        mode = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #(800000);
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule : tb_sqrt_iter
`default_nettype wire
